systolic_seq: RTL and testbench

- Sequencer for an N x N array of the team's 16x16->32 signed multiply-accumulate processing elements.
- Holds operand matrices A and B loaded by a host (PCPI coprocessor side) and clears the array before each job.
- Drives the skewed west (A) and north (B) feed streams, then samples the array's south result bus on a fixed schedule into a result register file.
- Signals completion to the host with busy and done.

---
 rtl/systolic_seq_pkg.sv | 28 ++
 rtl/systolic_skew_gen.sv | 31 +++
 rtl/systolic_seq.sv | 148 ++++++++++++++
 tb/tb_systolic_seq.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_seq_pkg.sv
// Shared definitions for the systolic MAC array sequencer: default sizes,
// FSM encoding and lane/matrix index helpers.
package systolic_seq_pkg;

   localparam int N_DEF       = 2;
   localparam int DW_DEF      = 16;
   localparam int RW_DEF      = 32;
   localparam int CAP_LAT_DEF = 2;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLEAR = 3'd1,
      S_FEED  = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   // Low bit of lane `lane` in a bus packed from `w`-bit lanes.
   function automatic int lane_lo(input int lane, input int w);
      return lane * w;
   endfunction

   // Row-major flat index of element (row, col) in an n x n matrix.
   function automatic int mat_idx(input int row, input int col, input int n);
      return row * n + col;
   endfunction

endpackage

// File: rtl/systolic_skew_gen.sv
// Combinational skew mapping: feed step t plus the A/B files -> west/north lanes.
// West lane i carries A[i][t-i], north lane j carries B[t-j][j], zero outside the band.
module systolic_skew_gen
   import systolic_seq_pkg::*;
#(
   parameter int N  = N_DEF,
   parameter int DW = DW_DEF,
   parameter int TW = 4
) (
   input  logic [TW-1:0]     t,
   input  logic [N*N*DW-1:0] a_mat,
   input  logic [N*N*DW-1:0] b_mat,
   output logic [N*DW-1:0]   a_lanes,
   output logic [N*DW-1:0]   b_lanes
);

   always_comb begin
      int k;
      a_lanes = '0;
      b_lanes = '0;
      k       = 0;
      for (int i = 0; i < N; i++) begin
         k = int'(t) - i;
         if (k >= 0 && k < N) begin
            a_lanes[lane_lo(i, DW) +: DW] = a_mat[lane_lo(mat_idx(i, k, N), DW) +: DW];
            b_lanes[lane_lo(i, DW) +: DW] = b_mat[lane_lo(mat_idx(k, i, N), DW) +: DW];
         end
      end
   end

endmodule

// File: rtl/systolic_seq.sv
// Job sequencer for an N x N output-stationary MAC array: holds A/B, clears the
// array, drives skewed feeds and captures the south result bus into C.
module systolic_seq
   import systolic_seq_pkg::*;
#(
   parameter int N       = N_DEF,
   parameter int DW      = DW_DEF,
   parameter int RW      = RW_DEF,
   parameter int CAP_LAT = CAP_LAT_DEF,
   localparam int AW     = (N * N > 1) ? $clog2(N * N) : 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            wr_en,
   input  logic            wr_sel,
   input  logic [AW-1:0]   wr_addr,
   input  logic [DW-1:0]   wr_data,
   input  logic            start,
   output logic            busy,
   output logic            done,
   input  logic [AW-1:0]   rd_addr,
   output logic [RW-1:0]   rd_data,
   output logic            array_clr,
   output logic            feed_valid,
   output logic [N*DW-1:0] a_feed,
   output logic [N*DW-1:0] b_feed,
   input  logic [N*RW-1:0] res_in,
   output state_t          dbg_state
);

   localparam int FEED_LAST = 2 * N - 2;
   localparam int T_LAST    = CAP_LAT + 2 * N - 2;
   localparam int TW        = $clog2(T_LAST + 2);
   localparam logic [TW-1:0] FEED_LAST_T = TW'(FEED_LAST);
   localparam logic [TW-1:0] T_LAST_T    = TW'(T_LAST);
   localparam logic          SKIP_DRAIN  = (T_LAST <= FEED_LAST);

   state_t              state, next_state;
   logic [TW-1:0]       t, t_next;
   logic [N*N*DW-1:0]   a_mat, b_mat;
   logic [RW-1:0]       c_mem [N*N];
   logic [N*DW-1:0]     skew_a, skew_b;
   logic [N-1:0]        cap_hit;
   logic [AW-1:0]       cap_idx [N];

   // Handshake: start is a one-cycle request honoured only in IDLE; the job is
   // acknowledged by busy from the next cycle and closed by a single done pulse.
   assign dbg_state  = state;
   assign busy       = (state == S_CLEAR) || (state == S_FEED) || (state == S_DRAIN);
   assign done       = (state == S_DONE);
   assign feed_valid = (state == S_FEED);
   assign array_clr  = rst || (state == S_CLEAR);
   assign rd_data    = c_mem[rd_addr];

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         t     <= '0;
      end else begin
         state <= next_state;
         t     <= t_next;
      end
   end

   always_comb begin
      next_state = state;
      t_next     = t;
      case (state)
         S_IDLE:  if (start) next_state = S_CLEAR;
         S_CLEAR: begin
            next_state = S_FEED;
            t_next     = '0;
         end
         S_FEED: begin
            t_next = t + 1'b1;
            if (t == FEED_LAST_T) next_state = SKIP_DRAIN ? S_DONE : S_DRAIN;
         end
         S_DRAIN: begin
            t_next = t + 1'b1;
            if (t == T_LAST_T) next_state = S_DONE;
         end
         S_DONE:  next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   // Operand files are writable only while idle so a running job sees stable data.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_mat <= '0;
         b_mat <= '0;
      end else if (state == S_IDLE && wr_en) begin
         if (!wr_sel) a_mat[lane_lo(int'(wr_addr), DW) +: DW] <= wr_data;
         else         b_mat[lane_lo(int'(wr_addr), DW) +: DW] <= wr_data;
      end
   end

   systolic_skew_gen #(
      .N  (N),
      .DW (DW),
      .TW (TW)
   ) u_skew (
      .t       (t_next),
      .a_mat   (a_mat),
      .b_mat   (b_mat),
      .a_lanes (skew_a),
      .b_lanes (skew_b)
   );

   // Feeds are computed one cycle ahead from t_next so step t lands in cycle t.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_feed <= '0;
         b_feed <= '0;
      end else if (next_state == S_FEED) begin
         a_feed <= skew_a;
         b_feed <= skew_b;
      end else begin
         a_feed <= '0;
         b_feed <= '0;
      end
   end

   always_comb begin
      int k;
      cap_hit = '0;
      k       = 0;
      for (int j = 0; j < N; j++) begin
         cap_idx[j] = '0;
         k = int'(t) - CAP_LAT - j;
         if (k >= 0 && k < N) begin
            cap_hit[j] = 1'b1;
            cap_idx[j] = AW'(mat_idx(k, j, N));
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || state == S_CLEAR) begin
         for (int e = 0; e < N * N; e++) c_mem[e] <= '0;
      end else if (state == S_FEED || state == S_DRAIN) begin
         for (int j = 0; j < N; j++) begin
            if (cap_hit[j]) c_mem[cap_idx[j]] <= res_in[lane_lo(j, RW) +: RW];
         end
      end
   end

endmodule

// File: tb/tb_systolic_seq.sv
// Directed bench for systolic_seq with a 2x2 output-stationary MAC array model
// on the feed/result buses.
module tb_systolic_seq;
   import systolic_seq_pkg::*;

   localparam int N  = 2;
   localparam int DW = 16;
   localparam int RW = 32;
   localparam int AW = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic            wr_en;
   logic            wr_sel;
   logic [AW-1:0]   wr_addr;
   logic [DW-1:0]   wr_data;
   logic            start;
   logic            busy;
   logic            done;
   logic [AW-1:0]   rd_addr;
   logic [RW-1:0]   rd_data;
   logic            array_clr;
   logic            feed_valid;
   logic [N*DW-1:0] a_feed;
   logic [N*DW-1:0] b_feed;
   logic [N*RW-1:0] res_in;
   state_t          dbg_state;

   int checks   = 0;
   int errors   = 0;
   int done_cnt = 0;
   int res_mode = 1;
   int tc       = 0;

   always #5 clk = ~clk;

   systolic_seq #(.N(N), .DW(DW), .RW(RW), .CAP_LAT(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (wr_en),
      .wr_sel     (wr_sel),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .start      (start),
      .busy       (busy),
      .done       (done),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .array_clr  (array_clr),
      .feed_valid (feed_valid),
      .a_feed     (a_feed),
      .b_feed     (b_feed),
      .res_in     (res_in),
      .dbg_state  (dbg_state)
   );

   // Array model: a moves east, b moves south, each PE accumulates a*b.
   logic signed [DW-1:0] a_r [N][N];
   logic signed [DW-1:0] b_r [N][N];
   logic signed [RW-1:0] acc [N][N];

   function automatic logic signed [DW-1:0] west_in(input int i, input int j);
      if (j == 0) return $signed(a_feed[i*DW +: DW]);
      return a_r[i][j-1];
   endfunction

   function automatic logic signed [DW-1:0] north_in(input int i, input int j);
      if (i == 0) return $signed(b_feed[j*DW +: DW]);
      return b_r[i-1][j];
   endfunction

   always @(posedge clk) begin
      tc <= array_clr ? 0 : tc + 1;
      if (done) done_cnt <= done_cnt + 1;
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            if (array_clr) begin
               a_r[i][j] <= '0;
               b_r[i][j] <= '0;
               acc[i][j] <= '0;
            end else begin
               a_r[i][j] <= west_in(i, j);
               b_r[i][j] <= north_in(i, j);
               acc[i][j] <= acc[i][j] + west_in(i, j) * north_in(i, j);
            end
         end
      end
   end

   // South bus: mode 1 drives 100*t+j, mode 0 presents row t-2-j of the model.
   always_comb begin
      int row;
      res_in = '0;
      row    = 0;
      for (int j = 0; j < N; j++) begin
         if (res_mode == 1) begin
            res_in[j*RW +: RW] = RW'(100 * tc + j);
         end else begin
            row = tc - 2 - j;
            if (row >= 0 && row < N) res_in[j*RW +: RW] = acc[row][j];
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_c(input string tag, input int idx, input int exp);
      rd_addr = AW'(idx);
      #1;
      chk(tag, rd_data, 32'(exp));
   endtask

   task automatic wr(input logic sel, input int addr, input int val);
      wr_en   = 1'b1;
      wr_sel  = sel;
      wr_addr = AW'(addr);
      wr_data = DW'(val);
      tick();
      wr_en   = 1'b0;
   endtask

   function automatic logic [31:0] lanes2(input int l1, input int l0);
      return {l1[15:0], l0[15:0]};
   endfunction

   initial begin
      int n;
      rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
      start = 1'b0; rd_addr = '0;

      // Reset state
      tick();
      chk("rst_array_clr", 32'(array_clr), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_feed_valid", 32'(feed_valid), 32'd0);
      chk("rst_a_feed", a_feed, 32'd0);
      chk("rst_state", 32'(dbg_state), 32'(S_IDLE));
      tick();
      rst = 1'b0;
      #1;
      chk("idle_array_clr", 32'(array_clr), 32'd0);
      chk_c("rst_c0", 0, 0);

      // Job 1: feed skew and capture schedule with a patterned south bus
      res_mode = 1;
      wr(1'b0, 0, 1); wr(1'b0, 1, 2); wr(1'b0, 2, 3); wr(1'b0, 3, 4);
      wr(1'b1, 0, 5); wr(1'b1, 1, 6); wr(1'b1, 2, 7); wr(1'b1, 3, 8);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("j1_clear_busy", 32'(busy), 32'd1);
      chk("j1_clear_array_clr", 32'(array_clr), 32'd1);
      chk("j1_clear_fv", 32'(feed_valid), 32'd0);
      tick();
      chk("j1_t0_fv", 32'(feed_valid), 32'd1);
      chk("j1_t0_a", a_feed, lanes2(0, 1));
      chk("j1_t0_b", b_feed, lanes2(0, 5));
      tick();
      chk("j1_t1_a", a_feed, lanes2(3, 2));
      chk("j1_t1_b", b_feed, lanes2(6, 7));
      tick();
      chk("j1_t2_a", a_feed, lanes2(4, 0));
      chk("j1_t2_b", b_feed, lanes2(8, 0));
      tick();
      chk("j1_t3_fv", 32'(feed_valid), 32'd0);
      chk("j1_t3_a", a_feed, 32'd0);
      chk("j1_t3_b", b_feed, 32'd0);
      chk("j1_t3_busy", 32'(busy), 32'd1);
      tick();
      chk("j1_t4_done", 32'(done), 32'd0);
      tick();
      chk("j1_done", 32'(done), 32'd1);
      chk("j1_done_busy", 32'(busy), 32'd0);
      chk_c("j1_c00", 0, 200);
      chk_c("j1_c01", 1, 301);
      chk_c("j1_c10", 2, 300);
      chk_c("j1_c11", 3, 401);
      tick();
      chk("j1_after_done", 32'(done), 32'd0);
      chk("j1_done_cnt", 32'(done_cnt), 32'd1);

      // Job 2: signed operands through the array model; start and wr_en mid-job
      res_mode = 0;
      wr(1'b0, 0, -32768); wr(1'b0, 1, 32767); wr(1'b0, 2, -1); wr(1'b0, 3, 2);
      wr(1'b1, 0, 2);      wr(1'b1, 1, -1);    wr(1'b1, 2, 3);  wr(1'b1, 3, -32768);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 2'd0; wr_data = 16'd99;
      start = 1'b1;
      tick();
      wr_en = 1'b0;
      start = 1'b0;
      tick();
      tick();
      tick();
      chk("j2_done", 32'(done), 32'd1);
      chk_c("j2_c00", 0, 32765);
      chk_c("j2_c01", 1, -1073676288);
      chk_c("j2_c10", 2, 4);
      chk_c("j2_c11", 3, -65535);
      tick();
      chk("j2_idle_busy", 32'(busy), 32'd0);
      chk("j2_done_cnt", 32'(done_cnt), 32'd2);

      // Job 3: back-to-back start with a same-cycle B write
      start = 1'b1;
      wr_en = 1'b1; wr_sel = 1'b1; wr_addr = 2'd0; wr_data = 16'd4;
      tick();
      start = 1'b0;
      wr_en = 1'b0;
      tick();
      chk("j3_t0_a_old", a_feed, lanes2(0, -32768));
      chk("j3_t0_b_new", b_feed, lanes2(0, 4));
      chk_c("j3_cleared_c00", 0, 0);
      chk_c("j3_cleared_c11", 3, 0);
      n = 0;
      while (!done && n < 20) begin
         tick();
         n++;
      end
      chk("j3_latency", 32'(n), 32'd5);
      chk_c("j3_c00", 0, -32771);
      chk_c("j3_c01", 1, -1073676288);
      chk_c("j3_c10", 2, 2);
      chk_c("j3_c11", 3, -65535);
      tick();
      chk("j3_done_cnt", 32'(done_cnt), 32'd3);

      // Job 4: reset mid-FEED
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      #1;
      chk("j4_rst_array_clr", 32'(array_clr), 32'd1);
      tick();
      chk("j4_rst_busy", 32'(busy), 32'd0);
      chk("j4_rst_fv", 32'(feed_valid), 32'd0);
      chk("j4_rst_a", a_feed, 32'd0);
      chk("j4_rst_b", b_feed, 32'd0);
      chk("j4_rst_array_clr2", 32'(array_clr), 32'd1);
      tick();
      tick();
      rst = 1'b0;
      tick();
      chk("j4_state", 32'(dbg_state), 32'(S_IDLE));
      chk("j4_array_clr_off", 32'(array_clr), 32'd0);
      chk_c("j4_c00", 0, 0);
      chk_c("j4_c01", 1, 0);
      repeat (8) tick();
      chk("j4_no_done", 32'(done_cnt), 32'd3);

      // Job 5: operand files were cleared by reset
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      chk("j5_t0_a", a_feed, 32'd0);
      chk("j5_t0_b", b_feed, 32'd0);
      n = 0;
      while (!done && n < 20) begin
         tick();
         n++;
      end
      chk("j5_done", 32'(done), 32'd1);
      tick();
      chk("j5_done_cnt", 32'(done_cnt), 32'd4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
